// File: rtl/secure_sram_port_ctrl.sv
// Key-load sequencer and 2-way round-robin arbiter in front of secure_sram_top.
// Define ACCESS_TIMEOUT_EN to enable the WAIT_RDY watchdog and rsp_err.
module secure_sram_port_ctrl #(
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 52,
    parameter int DCR_CYCLES     = 10,
    parameter int SETTLE_CYCLES  = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_load_req,
    input  logic [63:0]           key_a,
    input  logic [31:0]           key_d,
    output logic                  key_busy,
    output logic                  key_valid,
    input  logic [1:0]            rq_valid,
    input  logic [1:0]            rq_we,
    input  logic [2*ADDR_W-1:0]   rq_addr,
    input  logic [2*DATA_W-1:0]   rq_wdata,
    output logic [1:0]            rq_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  sram_dcr,
    output logic [63:0]           sram_trng_a,
    output logic [31:0]           sram_trng_d,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    input  logic [DATA_W-1:0]     sram_rdata,
    input  logic                  sram_ready
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_KEYLOAD = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_ISSUE   = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    localparam int CMAX0 = (DCR_CYCLES > SETTLE_CYCLES) ? DCR_CYCLES : SETTLE_CYCLES;
    localparam int CMAX  = (CMAX0 > TIMEOUT_CYCLES) ? CMAX0 : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam logic [CNT_W-1:0] DCR_LAST = CNT_W'(DCR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
`ifdef ACCESS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [63:0]       ka_q, ka_d;
    logic [31:0]       kd_q, kd_d;
    logic [63:0]       ta_q, ta_d;
    logic [31:0]       td_q, td_d;
    logic              kvalid_q, kvalid_d;
    logic              rr_q, rr_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef ACCESS_TIMEOUT_EN
    logic              err_q, err_d;
`endif
    logic              sel;

    assign key_busy = pend_q | (state_q == S_KEYLOAD) | (state_q == S_SETTLE);

    // Next-state logic: key-load sequencing, arbitration and access tracking
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        ka_d     = ka_q;
        kd_d     = kd_q;
        ta_d     = ta_q;
        td_d     = td_q;
        kvalid_d = kvalid_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef ACCESS_TIMEOUT_EN
        err_d    = err_q;
`endif
        rq_ready = 2'b00;
        sel      = 1'b0;

        if (key_load_req && !key_busy) begin
            pend_d = 1'b1;
            ka_d   = key_a;
            kd_d   = key_d;
        end

        unique case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    pend_d   = 1'b0;
                    ta_d     = ka_q;
                    td_d     = kd_q;
                    kvalid_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_KEYLOAD;
                end else if (kvalid_q && (rq_valid != 2'b00)) begin
                    sel      = (rq_valid == 2'b11) ? ~rr_q : rq_valid[1];
                    rq_ready = sel ? 2'b10 : 2'b01;
                    gnt_d    = sel;
                    we_d     = rq_we[sel];
                    addr_d   = sel ? rq_addr[2*ADDR_W-1:ADDR_W] : rq_addr[ADDR_W-1:0];
                    wdata_d  = sel ? rq_wdata[2*DATA_W-1:DATA_W] : rq_wdata[DATA_W-1:0];
                    cnt_d    = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_KEYLOAD: begin
                if (cnt_q == DCR_LAST) begin
                    cnt_d = '0;
                    if (SETTLE_CYCLES == 0) begin
                        kvalid_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_SETTLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SET_LAST) begin
                    cnt_d    = '0;
                    kvalid_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (sram_ready) begin
                    rdata_d = sram_rdata;
`ifdef ACCESS_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RESP;
`ifdef ACCESS_TIMEOUT_EN
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_WAIT;
                end
`else
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_RESP: begin
                rr_d    = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any access or key load in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            ka_q     <= '0;
            kd_q     <= '0;
            ta_q     <= '0;
            td_q     <= '0;
            kvalid_q <= 1'b0;
            rr_q     <= 1'b1;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef ACCESS_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            ka_q     <= ka_d;
            kd_q     <= kd_d;
            ta_q     <= ta_d;
            td_q     <= td_d;
            kvalid_q <= kvalid_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
`ifdef ACCESS_TIMEOUT_EN
            err_q    <= err_d;
`endif
        end
    end

    assign key_valid   = kvalid_q;
    assign sram_dcr    = (state_q == S_KEYLOAD);
    assign sram_trng_a = ta_q;
    assign sram_trng_d = td_q;
    assign sram_cs     = (state_q == S_ISSUE) | (state_q == S_WAIT);
    assign sram_we     = sram_cs & we_q;
    assign sram_addr   = addr_q;
    assign sram_wdata  = wdata_q;
    assign rsp_valid   = (state_q == S_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata   = rdata_q;
`ifdef ACCESS_TIMEOUT_EN
    assign rsp_err     = err_q;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_secure_sram_port_ctrl.sv
// Randomized scoreboard bench for secure_sram_port_ctrl with a behavioural SRAM.
// Timeout scenario is exercised only when ACCESS_TIMEOUT_EN is defined.
module tb_secure_sram_port_ctrl;

    localparam int AW = 14;
    localparam int DW = 52;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            key_load_req = 1'b0;
    logic [63:0]     key_a = '0;
    logic [31:0]     key_d = '0;
    logic            key_busy, key_valid;
    logic [1:0]      rq_valid = '0;
    logic [1:0]      rq_we = '0;
    logic [2*AW-1:0] rq_addr = '0;
    logic [2*DW-1:0] rq_wdata = '0;
    logic [1:0]      rq_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err, sram_dcr;
    logic [63:0]     sram_trng_a;
    logic [31:0]     sram_trng_d;
    logic            sram_cs, sram_we;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wdata;
    logic [DW-1:0]   sram_rdata;
    logic            sram_ready;

    always #5 clk = ~clk;

    secure_sram_port_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .key_load_req(key_load_req), .key_a(key_a), .key_d(key_d),
        .key_busy(key_busy), .key_valid(key_valid),
        .rq_valid(rq_valid), .rq_we(rq_we), .rq_addr(rq_addr),
        .rq_wdata(rq_wdata), .rq_ready(rq_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sram_dcr(sram_dcr), .sram_trng_a(sram_trng_a),
        .sram_trng_d(sram_trng_d), .sram_cs(sram_cs), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    typedef struct {
        int            g;
        logic [DW-1:0] d;
        logic          e;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            compares = 0;
    int            fails = 0;
    int            cyc = 0;
    int            rdy_cyc = -10;
    int            rr_last = 1;
    int            lat = 1;
    bit            stuck = 1'b0;
    int            wcnt = 0;
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] sram_mem [int];
    logic [223:0]  all_out;

    assign all_out = {key_busy, key_valid, rq_ready, rsp_valid, rsp_rdata,
                      rsp_err, sram_dcr, sram_trng_a, sram_trng_d, sram_cs,
                      sram_we, sram_addr, sram_wdata};

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: ready after 'lat' cycles of cs, read-before-write
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_ready <= 1'b0;
            sram_rdata <= '0;
            wcnt       <= 0;
        end else begin
            sram_ready <= 1'b0;
            if (!sram_cs) begin
                wcnt <= 0;
            end else if (!sram_ready && !stuck) begin
                if (wcnt >= lat) begin
                    sram_ready <= 1'b1;
                    sram_rdata <= sram_mem.exists(int'(sram_addr)) ?
                                  sram_mem[int'(sram_addr)] : '0;
                    if (sram_we) sram_mem[int'(sram_addr)] = sram_wdata;
                    wcnt <= 0;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    // Monitor: every completion is matched against the scoreboard head
    always @(negedge clk) begin
        if (sram_ready) rdy_cyc <= cyc;
        if (rst_n && rsp_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 256'(rsp_valid), 256'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_port", 256'(rsp_valid),
                    256'((mon_e.g == 1) ? 2'b10 : 2'b01));
                chk("rsp_rdata", 256'(rsp_rdata), 256'(mon_e.d));
                chk("rsp_err", 256'(rsp_err), 256'(mon_e.e));
                if (!mon_e.e)
                    chk("rsp_latency", 256'(cyc), 256'(rdy_cyc + 1));
            end
        end
    end

    task automatic set_rq(input int i, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq_valid[i] = 1'b1;
        rq_we[i] = w;
        if (i == 1) begin
            rq_addr[2*AW-1:AW]  = a;
            rq_wdata[2*DW-1:DW] = d;
        end else begin
            rq_addr[AW-1:0]  = a;
            rq_wdata[DW-1:0] = d;
        end
    endtask

    task automatic accept_one(output int g);
        int            eg;
        bit            got;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          w;
        exp_t          e;
        eg = (rq_valid == 2'b11) ? 1 - rr_last : (rq_valid[1] ? 1 : 0);
        g  = eg;
        #1;
        got = (rq_ready != 2'b00);
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            #1;
            got = (rq_ready != 2'b00);
        end
        chk("accept_seen", 256'(got), 256'(1));
        if (got) begin
            chk("grant", 256'(rq_ready), 256'((eg == 1) ? 2'b10 : 2'b01));
            a = (eg == 1) ? rq_addr[2*AW-1:AW] : rq_addr[AW-1:0];
            d = (eg == 1) ? rq_wdata[2*DW-1:DW] : rq_wdata[DW-1:0];
            w = rq_we[eg];
            e.g = eg;
            if (stuck) begin
                e.d = '0;
                e.e = 1'b1;
            end else begin
                e.d = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
                e.e = 1'b0;
                if (w) ref_mem[int'(a)] = d;
            end
            exp_q.push_back(e);
            rr_last = eg;
            @(negedge clk);
            #1;
            chk("cs_next", 256'(sram_cs), 256'(1));
            chk("addr_next", 256'(sram_addr), 256'(a));
            chk("we_next", 256'(sram_we), 256'(w));
            chk("wdata_next", 256'(sram_wdata), 256'(d));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            compares++;
            fails++;
            $display("FAIL drain: %0d outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic key_pulse(input logic [63:0] a, input logic [31:0] d);
        logic [63:0] r;
        @(negedge clk);
        key_load_req = 1'b1;
        key_a = a;
        key_d = d;
        @(negedge clk);
        r = {$urandom, $urandom};
        key_load_req = 1'b0;
        key_a = r;
        key_d = r[31:0] ^ 32'h5A5A_5A5A;
        #1;
        chk("busy_after_req", 256'(key_busy), 256'(1));
    endtask

    task automatic key_observe(input logic [63:0] a, input logic [31:0] d,
                               input bit chk_order);
        int t;
        int n;
        bit ok;
        t = 0;
        while (!sram_dcr && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("dcr_rise", 256'(sram_dcr), 256'(1));
        if (chk_order)
            chk("access_before_load", 256'(exp_q.size()), 256'(0));
        n = 0;
        ok = 1'b1;
        while (sram_dcr && n < 100) begin
            if (sram_trng_a !== a || sram_trng_d !== d || key_valid ||
                rq_ready != 2'b00 || !key_busy) ok = 1'b0;
            n++;
            @(negedge clk);
            #1;
        end
        chk("dcr_cycles", 256'(n), 256'(10));
        chk("dcr_window", 256'(ok), 256'(1));
        n = 0;
        ok = 1'b1;
        while (!key_valid && n < 100) begin
            if (sram_dcr || rq_ready != 2'b00 || !key_busy) ok = 1'b0;
            n++;
            @(negedge clk);
            #1;
        end
        chk("settle_cycles", 256'(n), 256'(5));
        chk("settle_window", 256'(ok), 256'(1));
        chk("trng_a_hold", 256'(sram_trng_a), 256'(a));
        chk("trng_d_hold", 256'(sram_trng_d), 256'(d));
        chk("busy_clear", 256'(key_busy), 256'(0));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            g;
        int            n;
        logic [5:0]    seq;
        logic [63:0]   r64;
        logic [DW-1:0] rd;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", 256'(all_out), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Requests stall before any key has been loaded
        set_rq(0, 1'b0, 14'd3, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("stall_no_key", 256'(rq_ready), 256'(0));
        end
        key_pulse(64'hDEAD_BEEF_CAFE_BABE, 32'h1234_5678);
        key_observe(64'hDEAD_BEEF_CAFE_BABE, 32'h1234_5678, 1'b0);
        lat = 1;
        accept_one(g);
        rq_valid = 2'b00;
        drain();

        // Write by req0 then read back by req1
        lat = 2;
        set_rq(0, 1'b1, 14'd5, 52'h0D);
        accept_one(g);
        rq_valid = 2'b00;
        drain();
        set_rq(1, 1'b0, 14'd5, '0);
        accept_one(g);
        rq_valid = 2'b00;
        drain();

        // Both requesters held: grants must alternate starting with req0
        lat = 0;
        set_rq(0, 1'b0, 14'd1, '0);
        set_rq(1, 1'b0, 14'd2, '0);
        for (int k = 0; k < 6; k++) begin
            accept_one(g);
            seq[k] = g[0];
        end
        rq_valid = 2'b00;
        chk("alt_sequence", 256'(seq), 256'(6'b101010));
        drain();

        // Random traffic; a losing requester keeps its request held
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!rq_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    r64 = {$urandom, $urandom};
                    rd = r64[DW-1:0];
                    set_rq(i, 1'($urandom_range(0, 1)),
                           14'($urandom_range(0, 7)), rd);
                end
            end
            if (rq_valid == 2'b00) begin
                r64 = {$urandom, $urandom};
                rd = r64[DW-1:0];
                set_rq(0, 1'($urandom_range(0, 1)),
                       14'($urandom_range(0, 7)), rd);
            end
            lat = $urandom_range(0, 3);
            accept_one(g);
            rq_valid[g] = 1'b0;
        end
        while (rq_valid != 2'b00) begin
            accept_one(g);
            rq_valid[g] = 1'b0;
        end
        drain();

        // Key load arriving mid-access waits; a second request is ignored
        lat = 6;
        set_rq(0, 1'b0, 14'd5, '0);
        accept_one(g);
        rq_valid = 2'b00;
        key_pulse(64'h0123_4567_89AB_CDEF, 32'hA5A5_0F0F);
        key_pulse(64'hFFFF_0000_FFFF_0000, 32'h0BAD_F00D);
        key_observe(64'h0123_4567_89AB_CDEF, 32'hA5A5_0F0F, 1'b1);
        lat = 1;

`ifdef ACCESS_TIMEOUT_EN
        // Stuck SRAM: cs held for the watchdog limit then an error response
        stuck = 1'b1;
        set_rq(1, 1'b1, 14'd6, 52'h123);
        accept_one(g);
        rq_valid = 2'b00;
        n = 1;
        while (sram_cs && n < 300) begin
            @(negedge clk);
            #1;
            if (sram_cs) n++;
        end
        chk("timeout_cs_cycles", 256'(n), 256'(64));
        stuck = 1'b0;
        drain();
`endif

        // Reset while waiting for ready aborts everything
        stuck = 1'b1;
        set_rq(1, 1'b1, 14'd4, 52'h77);
        accept_one(g);
        rq_valid = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk("in_wait_cs", 256'(sram_cs), 256'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_access", 256'(all_out), 256'(0));
        exp_q.delete();
        rr_last = 1;
        stuck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_rq(0, 1'b0, 14'd5, '0);
        set_rq(1, 1'b0, 14'd1, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("stall_after_reset", 256'(rq_ready), 256'(0));
        end
        key_pulse(64'h1111_2222_3333_4444, 32'h5555_6666);
        key_observe(64'h1111_2222_3333_4444, 32'h5555_6666, 1'b0);
        accept_one(g);
        rq_valid[g] = 1'b0;
        accept_one(g);
        rq_valid[g] = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
